// File: rtl/id_fwd_pipe_pkg.sv
// id_fwd_pipe_pkg: shared widths, register numbers and opcode constants for the ID/EX operand stage
package id_fwd_pipe_pkg;
    localparam int DATA_W   = 16;
    localparam int REG_AW   = 4;
    localparam int NFWD     = 2;
    localparam int ALUSEL_W = 3;
    localparam int ALUOP_W  = 8;
    localparam int CNT_W    = 4;

    localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic              RST_ENABLE   = 1'b1;
    localparam logic              WRITE_ENABLE = 1'b1;

    typedef enum logic [ALUSEL_W-1:0] {
        ALUSEL_NOP    = 3'd0,
        ALUSEL_LOGIC  = 3'd1,
        ALUSEL_SHIFT  = 3'd2,
        ALUSEL_ARITH  = 3'd3,
        ALUSEL_MEM    = 3'd4,
        ALUSEL_BRANCH = 3'd5
    } alusel_e;

    localparam logic [ALUOP_W-1:0] ALUOP_NOP  = 8'h00;
    localparam logic [ALUOP_W-1:0] ALUOP_ADDU = 8'h21;
    localparam logic [ALUOP_W-1:0] ALUOP_SUBU = 8'h23;
    localparam logic [ALUOP_W-1:0] ALUOP_AND  = 8'h24;
    localparam logic [ALUOP_W-1:0] ALUOP_OR   = 8'h25;
    localparam logic [ALUOP_W-1:0] ALUOP_LW   = 8'h30;

    typedef enum logic [REG_AW-1:0] {
        REG_R0 = 4'd0, REG_R1 = 4'd1, REG_R2 = 4'd2, REG_R3 = 4'd3,
        REG_R4 = 4'd4, REG_R5 = 4'd5, REG_R6 = 4'd6, REG_R7 = 4'd7,
        REG_SP = 4'd8, REG_T  = 4'd9, REG_IH = 4'd10, REG_RA = 4'd11
    } reg_e;
endpackage

// File: rtl/id_fwd_pipe_if.sv
// id_fwd_pipe_if: decode-in, forwarding-in, control-in and EX-out bundle of the ID/EX stage
//   master: decoder/pipeline side driving decode, forwarding, hold/flush; sees stall and ex_* outputs
//   slave : the id_fwd_pipe block
interface id_fwd_pipe_if #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int NFWD     = 2,
    parameter int ALUSEL_W = 3,
    parameter int ALUOP_W  = 8,
    parameter int CNT_W    = 4
);
    logic                     dec_valid;
    logic [ALUSEL_W-1:0]      dec_alusel;
    logic [ALUOP_W-1:0]       dec_aluop;
    logic                     dec_re0, dec_re1;
    logic [REG_AW-1:0]        dec_raddr0, dec_raddr1;
    logic [DATA_W-1:0]        dec_imm;
    logic                     dec_we;
    logic [REG_AW-1:0]        dec_waddr;
    logic                     dec_is_load;
    logic [DATA_W-1:0]        rf_rdata0, rf_rdata1;
    logic [NFWD-1:0]          fwd_we;
    logic [NFWD*REG_AW-1:0]   fwd_waddr;
    logic [NFWD*DATA_W-1:0]   fwd_wdata;
    logic [NFWD-1:0]          fwd_pending;
    logic                     hold_i, flush_i;
    logic                     stall_req;
    logic                     ex_valid, ex_we, ex_is_load;
    logic [ALUSEL_W-1:0]      ex_alusel;
    logic [ALUOP_W-1:0]       ex_aluop;
    logic [REG_AW-1:0]        ex_waddr;
    logic [DATA_W-1:0]        ex_op0, ex_op1, ex_imm;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output dec_valid, dec_alusel, dec_aluop, dec_re0, dec_re1, dec_raddr0, dec_raddr1,
               dec_imm, dec_we, dec_waddr, dec_is_load, rf_rdata0, rf_rdata1,
               fwd_we, fwd_waddr, fwd_wdata, fwd_pending, hold_i, flush_i,
        input  stall_req, ex_valid, ex_we, ex_is_load, ex_alusel, ex_aluop, ex_waddr,
               ex_op0, ex_op1, ex_imm, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_alusel, dec_aluop, dec_re0, dec_re1, dec_raddr0, dec_raddr1,
               dec_imm, dec_we, dec_waddr, dec_is_load, rf_rdata0, rf_rdata1,
               fwd_we, fwd_waddr, fwd_wdata, fwd_pending, hold_i, flush_i,
        output stall_req, ex_valid, ex_we, ex_is_load, ex_alusel, ex_aluop, ex_waddr,
               ex_op0, ex_op1, ex_imm, stall_cnt
    );
endinterface

// File: rtl/id_fwd_pipe_fwd_mux.sv
// id_fwd_pipe_fwd_mux: priority forwarding selector for one read port
//   raddr/rdata: port address and register-file data
//   fwd_*: per-source write enable, address, data, pending (source 0 youngest)
//   value/pending: resolved operand and whether the winning source is not yet available
module id_fwd_pipe_fwd_mux #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int NFWD   = 2
) (
    input  logic [REG_AW-1:0]      raddr,
    input  logic [DATA_W-1:0]      rdata,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*REG_AW-1:0] fwd_waddr,
    input  logic [NFWD*DATA_W-1:0] fwd_wdata,
    input  logic [NFWD-1:0]        fwd_pending,
    output logic [DATA_W-1:0]      value,
    output logic                   pending
);
    // Walk oldest to youngest so the youngest match is the last assignment and wins.
    always_comb begin
        value   = rdata;
        pending = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_waddr[i*REG_AW +: REG_AW] == raddr) begin
                value   = fwd_wdata[i*DATA_W +: DATA_W];
                pending = fwd_pending[i];
            end
        end
    end
endmodule

// File: rtl/id_fwd_pipe.sv
// id_fwd_pipe: operand forwarding, load-use interlock and ID/EX pipeline register
//   clk, rst: clock and asynchronous active-high reset
//   bus     : decode/forwarding/control inputs, stall_req, registered ex_* fields and stall_cnt
module id_fwd_pipe
    import id_fwd_pipe_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int NFWD     = 2,
    parameter int ALUSEL_W = 3,
    parameter int ALUOP_W  = 8,
    parameter int CNT_W    = 4
) (
    input logic        clk,
    input logic        rst,
    id_fwd_pipe_if.slave bus
);
    logic [DATA_W-1:0] val0, val1, op0, op1;
    logic              pend0, pend1, stall, bubble;

    id_fwd_pipe_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NFWD(NFWD)) u_mux0 (
        .raddr(bus.dec_raddr0), .rdata(bus.rf_rdata0), .fwd_we(bus.fwd_we),
        .fwd_waddr(bus.fwd_waddr), .fwd_wdata(bus.fwd_wdata), .fwd_pending(bus.fwd_pending),
        .value(val0), .pending(pend0)
    );

    id_fwd_pipe_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NFWD(NFWD)) u_mux1 (
        .raddr(bus.dec_raddr1), .rdata(bus.rf_rdata1), .fwd_we(bus.fwd_we),
        .fwd_waddr(bus.fwd_waddr), .fwd_wdata(bus.fwd_wdata), .fwd_pending(bus.fwd_pending),
        .value(val1), .pending(pend1)
    );

    assign op0   = bus.dec_re0 ? val0 : ZERO_WORD[DATA_W-1:0];
    assign op1   = bus.dec_re1 ? val1 : bus.dec_imm;
    assign stall = bus.dec_valid && ((bus.dec_re0 && pend0) || (bus.dec_re1 && pend1));
    assign bus.stall_req = stall;
    // Flush wins over hold; an interlock bubble only lands when the stage is free to advance.
    assign bubble = bus.flush_i || (!bus.hold_i && stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_we      <= 1'b0;
            bus.ex_is_load <= 1'b0;
            bus.ex_alusel  <= '0;
            bus.ex_aluop   <= '0;
            bus.ex_waddr   <= '0;
            bus.ex_op0     <= '0;
            bus.ex_op1     <= '0;
            bus.ex_imm     <= '0;
        end else if (bubble) begin
            bus.ex_valid   <= 1'b0;
            bus.ex_we      <= 1'b0;
            bus.ex_is_load <= 1'b0;
            bus.ex_alusel  <= '0;
            bus.ex_aluop   <= '0;
            bus.ex_waddr   <= '0;
            bus.ex_op0     <= '0;
            bus.ex_op1     <= '0;
            bus.ex_imm     <= '0;
        end else if (!bus.hold_i) begin
            bus.ex_valid   <= bus.dec_valid;
            bus.ex_we      <= bus.dec_we && bus.dec_valid;
            bus.ex_is_load <= bus.dec_is_load && bus.dec_valid;
            bus.ex_alusel  <= bus.dec_alusel;
            bus.ex_aluop   <= bus.dec_aluop;
            bus.ex_waddr   <= bus.dec_waddr;
            bus.ex_op0     <= op0;
            bus.ex_op1     <= op1;
            bus.ex_imm     <= bus.dec_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.stall_cnt <= '0;
        else if (!bus.hold_i)
            bus.stall_cnt <= !stall ? '0 : (&bus.stall_cnt) ? bus.stall_cnt : bus.stall_cnt + CNT_W'(1);
    end
endmodule
